// File: rtl/ix_pkg.sv
// Purpose: shared operation and FSM encodings for the execute stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package ix_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_ROL   = 4'd8,
    OP_SEQ   = 4'd9,
    OP_SLT   = 4'd10,
    OP_SLE   = 4'd11,
    OP_LUI   = 4'd12,
    OP_MUL   = 4'd13,
    OP_PASSA = 4'd14,
    OP_PASSB = 4'd15
  } ix_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_RUN  = 2'd1,
    ST_MUL_DONE = 2'd2
  } ix_state_t;

endpackage

// File: rtl/ix_mul_iter.sv
// Purpose: iterative shift-add multiplier, low DATA_W bits of the product.
// Latency: DATA_W cycles after start; done is high in the last iteration cycle.
// Backpressure: none internally; the final product is held on result until the next start.
module ix_mul_iter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_step;
  logic [CNT_W-1:0]  cnt;

  // The last iteration is folded in combinationally so the product is
  // available during the done cycle without an extra register stage.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;
  assign done     = busy & (cnt == '0);
  assign result   = busy ? acc_step : acc;

  // Operand shift registers, accumulator and down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      cnt    <= CNT_W'(DATA_W - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// Purpose: execute stage - operand forwarding, single-cycle ALU, iterative MUL, branch redirect.
// Latency: 1 cycle for ALU ops, DATA_W cycles for MUL (more if the memory stage stalls).
// Backpressure: ready to decode drops on load-use, busy MUL, flush, or a full output register.
module execute_pipe
  import ix_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  NREG   = 8,
  localparam int IDX_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_p1,
  input  logic              valid_idix_p1,
  output logic              ready_idix_p1,
  input  logic [3:0]        op_idix_p1,
  input  logic [IDX_W-1:0]  rs_idx_idix_p1,
  input  logic [IDX_W-1:0]  rt_idx_idix_p1,
  input  logic [DATA_W-1:0] rs_val_idix_p1,
  input  logic [DATA_W-1:0] rt_val_idix_p1,
  input  logic [DATA_W-1:0] imm_idix_p1,
  input  logic              use_imm_idix_p1,
  input  logic [IDX_W-1:0]  dest_idx_idix_p1,
  input  logic              reg_wr_idix_p1,
  input  logic              ld_idix_p1,
  input  logic              st_idix_p1,
  input  logic              branch_idix_p1,
  input  logic [DATA_W-1:0] pc_idix_p1,
  input  logic [IDX_W-1:0]  dest_idx_memwb_p1,
  input  logic [DATA_W-1:0] dest_val_memwb_p1,
  input  logic              dest_wr_memwb_p1,
  output logic              valid_ixmem_p1,
  input  logic              ready_ixmem_p1,
  output logic [DATA_W-1:0] result_ixmem_p1,
  output logic [DATA_W-1:0] st_data_ixmem_p1,
  output logic [IDX_W-1:0]  dest_idx_ixmem_p1,
  output logic              reg_wr_ixmem_p1,
  output logic              ld_ixmem_p1,
  output logic              st_ixmem_p1,
  output logic              branch_taken_ixif_p1,
  output logic [DATA_W-1:0] branch_target_ixif_p1
);

  localparam int SH_W = $clog2(DATA_W);

  ix_op_t            op;
  ix_state_t         state;
  ix_state_t         state_nxt;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_res;
  logic [SH_W-1:0]   shamt;
  logic [SH_W:0]     rot_r;
  logic              ix_fwd_ok;
  logic              rt_used;
  logic              loaduse;
  logic              slot_free;
  logic              accept;
  logic              is_mul;
  logic              single_load;
  logic              mul_start;
  logic              mul_load;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_res;
  logic [IDX_W-1:0]  mul_dest;
  logic              mul_wr;

  assign op = ix_op_t'(op_idix_p1);

  // Loads land in ixmem as addresses, so they are never a forwarding source.
  assign ix_fwd_ok = valid_ixmem_p1 & reg_wr_ixmem_p1 & ~ld_ixmem_p1;

  // Operand forwarding: ixmem register beats MEM/WB, which beats the regfile read.
  always_comb begin
    opa    = rs_val_idix_p1;
    fwd_rt = rt_val_idix_p1;
    if (dest_wr_memwb_p1 && (dest_idx_memwb_p1 == rs_idx_idix_p1)) opa    = dest_val_memwb_p1;
    if (dest_wr_memwb_p1 && (dest_idx_memwb_p1 == rt_idx_idix_p1)) fwd_rt = dest_val_memwb_p1;
    if (ix_fwd_ok && (dest_idx_ixmem_p1 == rs_idx_idix_p1))        opa    = result_ixmem_p1;
    if (ix_fwd_ok && (dest_idx_ixmem_p1 == rt_idx_idix_p1))        fwd_rt = result_ixmem_p1;
  end

  assign opb = use_imm_idix_p1 ? imm_idix_p1 : fwd_rt;

  // Stores still read rt (as store data) even when B comes from the immediate.
  assign rt_used   = ~use_imm_idix_p1 | st_idix_p1;
  assign loaduse   = valid_ixmem_p1 & ld_ixmem_p1 & reg_wr_ixmem_p1 &
                     ((dest_idx_ixmem_p1 == rs_idx_idix_p1) |
                      (rt_used & (dest_idx_ixmem_p1 == rt_idx_idix_p1)));
  assign slot_free = ~valid_ixmem_p1 | ready_ixmem_p1;

  assign ready_idix_p1 = (state == ST_IDLE) & ~mul_busy & ~loaduse & slot_free & ~flush_p1;
  assign accept        = valid_idix_p1 & ready_idix_p1;
  assign is_mul        = (op == OP_MUL);
  assign single_load   = accept & ~is_mul;

  assign shamt = opb[SH_W-1:0];
  assign rot_r = (SH_W + 1)'(DATA_W) - {1'b0, shamt};

  // Single-cycle ALU.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = opa + opb;
      OP_SUB:   alu_res = opa - opb;
      OP_AND:   alu_res = opa & opb;
      OP_OR:    alu_res = opa | opb;
      OP_XOR:   alu_res = opa ^ opb;
      OP_SLL:   alu_res = opa << shamt;
      OP_SRL:   alu_res = opa >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(opa) >>> shamt);
      OP_ROL:   alu_res = (opa << shamt) | (opa >> rot_r);
      OP_SEQ:   alu_res = {{(DATA_W-1){1'b0}}, (opa == opb)};
      OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) <  $signed(opb))};
      OP_SLE:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) <= $signed(opb))};
      OP_LUI:   alu_res = {opb[DATA_W/2-1:0], opa[DATA_W/2-1:0]};
      OP_PASSA: alu_res = opa;
      OP_PASSB: alu_res = opb;
      default:  alu_res = '0;
    endcase
  end

  ix_mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .abort  (flush_p1),
    .op_a   (opa),
    .op_b   (opb),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_res)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; a MUL result is only handed over while memory is ready,
  // otherwise it parks in MUL_DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul) state_nxt = ST_MUL_RUN;
      end
      ST_MUL_RUN: begin
        if (flush_p1)      state_nxt = ST_IDLE;
        else if (mul_done) state_nxt = ready_ixmem_p1 ? ST_IDLE : ST_MUL_DONE;
      end
      ST_MUL_DONE: begin
        if (flush_p1 || ready_ixmem_p1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: multiplier start and product hand-over into ixmem.
  always_comb begin
    mul_start = 1'b0;
    mul_load  = 1'b0;
    if ((state == ST_IDLE) && accept && is_mul) mul_start = 1'b1;
    if (!flush_p1 && ready_ixmem_p1 &&
        (((state == ST_MUL_RUN) && mul_done) || (state == ST_MUL_DONE))) mul_load = 1'b1;
  end

  // Destination bookkeeping for the multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_dest <= '0;
      mul_wr   <= 1'b0;
    end else if (mul_start) begin
      mul_dest <= dest_idx_idix_p1;
      mul_wr   <= reg_wr_idix_p1;
    end
  end

  // ixmem output register and one-cycle branch redirect pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_ixmem_p1        <= 1'b0;
      result_ixmem_p1       <= '0;
      st_data_ixmem_p1      <= '0;
      dest_idx_ixmem_p1     <= '0;
      reg_wr_ixmem_p1       <= 1'b0;
      ld_ixmem_p1           <= 1'b0;
      st_ixmem_p1           <= 1'b0;
      branch_taken_ixif_p1  <= 1'b0;
      branch_target_ixif_p1 <= '0;
    end else if (flush_p1) begin
      valid_ixmem_p1       <= 1'b0;
      branch_taken_ixif_p1 <= 1'b0;
    end else if (single_load) begin
      valid_ixmem_p1       <= 1'b1;
      result_ixmem_p1      <= alu_res;
      st_data_ixmem_p1     <= fwd_rt;
      dest_idx_ixmem_p1    <= dest_idx_idix_p1;
      reg_wr_ixmem_p1      <= reg_wr_idix_p1;
      ld_ixmem_p1          <= ld_idix_p1;
      st_ixmem_p1          <= st_idix_p1;
      branch_taken_ixif_p1 <= branch_idix_p1 & alu_res[0];
      if (branch_idix_p1) branch_target_ixif_p1 <= pc_idix_p1 + imm_idix_p1;
    end else if (mul_load) begin
      valid_ixmem_p1       <= 1'b1;
      result_ixmem_p1      <= mul_res;
      st_data_ixmem_p1     <= '0;
      dest_idx_ixmem_p1    <= mul_dest;
      reg_wr_ixmem_p1      <= mul_wr;
      ld_ixmem_p1          <= 1'b0;
      st_ixmem_p1          <= 1'b0;
      branch_taken_ixif_p1 <= 1'b0;
    end else begin
      if (ready_ixmem_p1) valid_ixmem_p1 <= 1'b0;
      branch_taken_ixif_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Purpose: directed self-checking bench for execute_pipe with an output scoreboard.
// Latency: expects 1 cycle for ALU ops and DATA_W cycles for MUL.
// Backpressure: drives ready_ixmem low in several phases and checks holding.
module tb_execute_pipe;
  import ix_pkg::*;

  localparam int DW = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_p1;
  logic          valid_idix_p1;
  logic          ready_idix_p1;
  logic [3:0]    op_idix_p1;
  logic [IW-1:0] rs_idx_idix_p1, rt_idx_idix_p1;
  logic [DW-1:0] rs_val_idix_p1, rt_val_idix_p1, imm_idix_p1;
  logic          use_imm_idix_p1;
  logic [IW-1:0] dest_idx_idix_p1;
  logic          reg_wr_idix_p1, ld_idix_p1, st_idix_p1, branch_idix_p1;
  logic [DW-1:0] pc_idix_p1;
  logic [IW-1:0] dest_idx_memwb_p1;
  logic [DW-1:0] dest_val_memwb_p1;
  logic          dest_wr_memwb_p1;
  logic          valid_ixmem_p1, ready_ixmem_p1;
  logic [DW-1:0] result_ixmem_p1, st_data_ixmem_p1;
  logic [IW-1:0] dest_idx_ixmem_p1;
  logic          reg_wr_ixmem_p1, ld_ixmem_p1, st_ixmem_p1;
  logic          branch_taken_ixif_p1;
  logic [DW-1:0] branch_target_ixif_p1;

  execute_pipe #(.DATA_W(DW), .NREG(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush_p1              (flush_p1),
    .valid_idix_p1         (valid_idix_p1),
    .ready_idix_p1         (ready_idix_p1),
    .op_idix_p1            (op_idix_p1),
    .rs_idx_idix_p1        (rs_idx_idix_p1),
    .rt_idx_idix_p1        (rt_idx_idix_p1),
    .rs_val_idix_p1        (rs_val_idix_p1),
    .rt_val_idix_p1        (rt_val_idix_p1),
    .imm_idix_p1           (imm_idix_p1),
    .use_imm_idix_p1       (use_imm_idix_p1),
    .dest_idx_idix_p1      (dest_idx_idix_p1),
    .reg_wr_idix_p1        (reg_wr_idix_p1),
    .ld_idix_p1            (ld_idix_p1),
    .st_idix_p1            (st_idix_p1),
    .branch_idix_p1        (branch_idix_p1),
    .pc_idix_p1            (pc_idix_p1),
    .dest_idx_memwb_p1     (dest_idx_memwb_p1),
    .dest_val_memwb_p1     (dest_val_memwb_p1),
    .dest_wr_memwb_p1      (dest_wr_memwb_p1),
    .valid_ixmem_p1        (valid_ixmem_p1),
    .ready_ixmem_p1        (ready_ixmem_p1),
    .result_ixmem_p1       (result_ixmem_p1),
    .st_data_ixmem_p1      (st_data_ixmem_p1),
    .dest_idx_ixmem_p1     (dest_idx_ixmem_p1),
    .reg_wr_ixmem_p1       (reg_wr_ixmem_p1),
    .ld_ixmem_p1           (ld_ixmem_p1),
    .st_ixmem_p1           (st_ixmem_p1),
    .branch_taken_ixif_p1  (branch_taken_ixif_p1),
    .branch_target_ixif_p1 (branch_target_ixif_p1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] result;
    logic [IW-1:0] dest;
    logic          reg_wr;
    logic          ld;
    logic          st;
    logic [DW-1:0] st_data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_asserts = 0;
  int   n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [DW-1:0] res, input logic [IW-1:0] dst,
                            input logic wr, input logic ld, input logic st,
                            input logic [DW-1:0] sd);
    exp_t e;
    e.result = res; e.dest = dst; e.reg_wr = wr; e.ld = ld; e.st = st; e.st_data = sd;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [IW-1:0] rs, input logic [IW-1:0] rt,
                       input logic [DW-1:0] rsv, input logic [DW-1:0] rtv, input logic [DW-1:0] imm,
                       input logic ui, input logic [IW-1:0] dst, input logic wr,
                       input logic ld, input logic st, input logic br, input logic [DW-1:0] pc);
    op_idix_p1 = op; rs_idx_idix_p1 = rs; rt_idx_idix_p1 = rt;
    rs_val_idix_p1 = rsv; rt_val_idix_p1 = rtv; imm_idix_p1 = imm;
    use_imm_idix_p1 = ui; dest_idx_idix_p1 = dst; reg_wr_idix_p1 = wr;
    ld_idix_p1 = ld; st_idix_p1 = st; branch_idix_p1 = br; pc_idix_p1 = pc;
    valid_idix_p1 = 1'b1;
  endtask

  // Holds the driven op until the DUT accepts it; returns 1 time unit after the accept edge.
  task automatic send();
    int n;
    n = 0;
    #1;
    while (!ready_idix_p1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_wait", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1;
    valid_idix_p1 = 1'b0;
  endtask

  task automatic alu_case(input logic [3:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] res);
    drive(op, 3'd1, 3'd2, a, 16'h0, b, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_out(res, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    send();
  endtask

  // Scoreboard: every transfer into the memory stage is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && valid_ixmem_p1 && ready_ixmem_p1) begin
      n_asserts++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed result 0x%0h expected no output", result_ixmem_p1);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sb_result", 32'(result_ixmem_p1), 32'(mon_e.result));
        chk("sb_dest", 32'(dest_idx_ixmem_p1), 32'(mon_e.dest));
        chk("sb_reg_wr", 32'(reg_wr_ixmem_p1), 32'(mon_e.reg_wr));
        chk("sb_ld", 32'(ld_ixmem_p1), 32'(mon_e.ld));
        chk("sb_st", 32'(st_ixmem_p1), 32'(mon_e.st));
        if (mon_e.st) chk("sb_st_data", 32'(st_data_ixmem_p1), 32'(mon_e.st_data));
      end
    end
  end

  initial begin
    int n;
    int rl;
    int stale;
    logic [31:0] prod;

    rst = 1'b1; flush_p1 = 1'b0; valid_idix_p1 = 1'b0; op_idix_p1 = 4'd0;
    rs_idx_idix_p1 = '0; rt_idx_idix_p1 = '0; rs_val_idix_p1 = '0; rt_val_idix_p1 = '0;
    imm_idix_p1 = '0; use_imm_idix_p1 = 1'b0; dest_idx_idix_p1 = '0; reg_wr_idix_p1 = 1'b0;
    ld_idix_p1 = 1'b0; st_idix_p1 = 1'b0; branch_idix_p1 = 1'b0; pc_idix_p1 = '0;
    dest_idx_memwb_p1 = '0; dest_val_memwb_p1 = '0; dest_wr_memwb_p1 = 1'b0;
    ready_ixmem_p1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_valid", 32'(valid_ixmem_p1), 32'd0);
    chk("rst_result", 32'(result_ixmem_p1), 32'd0);
    chk("rst_dest", 32'(dest_idx_ixmem_p1), 32'd0);
    chk("rst_ctl", {29'd0, reg_wr_ixmem_p1, ld_ixmem_p1, st_ixmem_p1}, 32'd0);
    chk("rst_taken", 32'(branch_taken_ixif_p1), 32'd0);
    chk("rst_target", 32'(branch_target_ixif_p1), 32'd0);
    chk("rst_ready", 32'(ready_idix_p1), 32'd1);
    tick();

    // Reset in the middle of a multiply
    drive(OP_MUL, 3'd1, 3'd2, 16'h00FF, 16'h0102, 16'h0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    send();
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("rstmul_valid_async", 32'(valid_ixmem_p1), 32'd0);
    chk("rstmul_result_async", 32'(result_ixmem_p1), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmul_ready", 32'(ready_idix_p1), 32'd1);
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_ixmem_p1) stale++;
      tick();
    end
    chk("rstmul_no_stale_valid", 32'(stale), 32'd0);

    // ADD then dependent SUB; ixmem value beats the simultaneous MEM/WB write of r1
    drive(OP_ADD, 3'd4, 3'd5, 16'd3, 16'd4, 16'h0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_out(16'd7, 3'd1, 1'b1, 1'b0, 1'b0, 16'd4);
    send();
    chk("add_result", 32'(result_ixmem_p1), 32'd7);
    drive(OP_SUB, 3'd1, 3'd0, 16'd0, 16'd0, 16'd2, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    dest_idx_memwb_p1 = 3'd1; dest_val_memwb_p1 = 16'd9; dest_wr_memwb_p1 = 1'b1;
    expect_out(16'd5, 3'd2, 1'b1, 1'b0, 1'b0, 16'd0);
    send();
    dest_wr_memwb_p1 = 1'b0;
    chk("fwd_ixmem_wins", 32'(result_ixmem_p1), 32'd5);
    repeat (2) tick();

    // Load-use stall, then MEM/WB forwarding of the loaded value
    drive(OP_ADD, 3'd6, 3'd0, 16'h0100, 16'h0, 16'h0008, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    expect_out(16'h0108, 3'd3, 1'b1, 1'b1, 1'b0, 16'h0);
    send();
    drive(OP_ADD, 3'd3, 3'd3, 16'h0, 16'h0, 16'h0001, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    #1;
    chk("loaduse_stall", 32'(ready_idix_p1), 32'd0);
    tick();
    dest_idx_memwb_p1 = 3'd3; dest_val_memwb_p1 = 16'h1234; dest_wr_memwb_p1 = 1'b1;
    #1;
    chk("loaduse_release", 32'(ready_idix_p1), 32'd1);
    expect_out(16'h1235, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0);
    tick();
    valid_idix_p1 = 1'b0;
    dest_wr_memwb_p1 = 1'b0;
    chk("memwb_fwd", 32'(result_ixmem_p1), 32'h1235);
    tick();

    // Multiply, unblocked
    prod = 32'h00FF * 32'h0102;
    drive(OP_MUL, 3'd1, 3'd2, 16'h00FF, 16'h0102, 16'h0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_out(prod[15:0], 3'd4, 1'b1, 1'b0, 1'b0, 16'h0);
    send();
    n = 0; rl = 0;
    while (!valid_ixmem_p1 && n < 40) begin
      if (!ready_idix_p1) rl++;
      tick();
      n++;
    end
    chk("mul_latency", 32'(n), 32'd16);
    chk("mul_ready_low_cycles", 32'(rl), 32'd16);
    chk("mul_result", 32'(result_ixmem_p1), 32'(prod[15:0]));
    chk("mul_ready_after", 32'(ready_idix_p1), 32'd1);
    tick();

    // Multiply with the memory stage stalled past completion
    prod = 32'd7 * 32'd9;
    drive(OP_MUL, 3'd1, 3'd2, 16'd7, 16'd9, 16'h0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_out(prod[15:0], 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    send();
    ready_ixmem_p1 = 1'b0;
    repeat (18) tick();
    chk("muldone_hold_valid", 32'(valid_ixmem_p1), 32'd0);
    chk("muldone_ready_low", 32'(ready_idix_p1), 32'd0);
    ready_ixmem_p1 = 1'b1;
    tick();
    chk("muldone_deliver", 32'(valid_ixmem_p1), 32'd1);
    chk("muldone_result", 32'(result_ixmem_p1), 32'(prod[15:0]));
    tick();
    chk("muldone_once", 32'(valid_ixmem_p1), 32'd0);

    // Backpressure: pending op holds fields, queued op loads on consume
    drive(OP_ADD, 3'd4, 3'd0, 16'h0010, 16'h0, 16'h0020, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_out(16'h0030, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0);
    send();
    ready_ixmem_p1 = 1'b0;
    drive(OP_OR, 3'd5, 3'd0, 16'h00F0, 16'h0, 16'h000F, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_out(16'h00FF, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready_low", 32'(ready_idix_p1), 32'd0);
      chk("bp_hold_result", 32'(result_ixmem_p1), 32'h0030);
      chk("bp_hold_dest", 32'(dest_idx_ixmem_p1), 32'd1);
      tick();
    end
    ready_ixmem_p1 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ready_idix_p1), 32'd1);
    tick();
    valid_idix_p1 = 1'b0;
    chk("bp_same_cycle_valid", 32'(valid_ixmem_p1), 32'd1);
    chk("bp_same_cycle_result", 32'(result_ixmem_p1), 32'h00FF);
    tick();

    // ALU corner cases (no writeback, so no forwarding between them)
    alu_case(OP_SRA, 16'h8010, 16'h0004, 16'hF801);
    alu_case(OP_ROL, 16'h8001, 16'h0001, 16'h0003);
    alu_case(OP_ROL, 16'h1234, 16'h0004, 16'h2341);
    alu_case(OP_SLT, 16'hFFFF, 16'h0001, 16'h0001);
    alu_case(OP_SLT, 16'h0001, 16'hFFFF, 16'h0000);
    alu_case(OP_SLE, 16'h0005, 16'h0005, 16'h0001);
    alu_case(OP_LUI, 16'h1234, 16'h5678, 16'h7834);
    alu_case(OP_SLL, 16'h0001, 16'h000F, 16'h8000);
    alu_case(OP_SLL, 16'h0003, 16'h0011, 16'h0006);
    alu_case(OP_SRL, 16'h8000, 16'h000F, 16'h0001);
    alu_case(OP_SUB, 16'h0000, 16'h0001, 16'hFFFF);
    alu_case(OP_ADD, 16'hFFFF, 16'h0002, 16'h0001);
    alu_case(OP_XOR, 16'hA5A5, 16'hFFFF, 16'h5A5A);

    // Store: address from immediate, store data from rt
    drive(OP_ADD, 3'd1, 3'd2, 16'h0200, 16'hBEEF, 16'h0004, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    expect_out(16'h0204, 3'd0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    send();
    repeat (2) tick();

    // Taken branch: one-cycle pulse and registered target
    drive(OP_SEQ, 3'd4, 3'd5, 16'd5, 16'd5, 16'h0004, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
    expect_out(16'h0001, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    send();
    chk("br_taken", 32'(branch_taken_ixif_p1), 32'd1);
    chk("br_target", 32'(branch_target_ixif_p1), 32'h0014);
    tick();
    chk("br_pulse_one_cycle", 32'(branch_taken_ixif_p1), 32'd0);
    tick();

    // Same branch with a concurrent flush: dropped, no pulse
    drive(OP_SEQ, 3'd4, 3'd5, 16'd5, 16'd5, 16'h0004, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
    flush_p1 = 1'b1;
    #1;
    chk("flush_ready_low", 32'(ready_idix_p1), 32'd0);
    tick();
    flush_p1 = 1'b0;
    valid_idix_p1 = 1'b0;
    chk("flush_no_pulse", 32'(branch_taken_ixif_p1), 32'd0);
    chk("flush_no_valid", 32'(valid_ixmem_p1), 32'd0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
